// File: rtl/merge_radio_transmit.sv
// merge_radio_transmit
// Merges two byte sources (Radio, Wire) onto one differential serial pair.
// Round-robin arbitration picks a source while idle. The chosen payload is
// framed and then serialized:
//   start(0), tag(1=Radio/0=Wire), data LSB first, even parity over tag+data,
//   stop(1).
// Each bit is held for CLKS_PER_BIT cycles. The serial bit then passes through
// a PIPE_STAGES-deep register chain before reaching the pins.
//
// Ports:
//   Clock          : single clock, rising edge
//   Reset_N        : asynchronous active-low reset
//   RadioData/Valid/Ready : radio byte source handshake
//   WireData/Valid/Ready  : wire byte source handshake
//   Transmit_Plus  : serial line, true polarity (idle 1)
//   Transmit_Minus : complement of Transmit_Plus
//   Busy           : high while a frame is being serialized
module merge_radio_transmit #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PIPE_STAGES  = 3
) (
  input  logic                  Clock,
  input  logic                  Reset_N,
  input  logic [DATA_WIDTH-1:0] RadioData,
  input  logic                  RadioValid,
  output logic                  RadioReady,
  input  logic [DATA_WIDTH-1:0] WireData,
  input  logic                  WireValid,
  output logic                  WireReady,
  output logic                  Transmit_Plus,
  output logic                  Transmit_Minus,
  output logic                  Busy
);

  localparam int FRAME_BITS = DATA_WIDTH + 4;
  localparam int BW = $clog2(FRAME_BITS);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);
  localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;
  logic                    r_last_radio;   // 1 when the previous grant went to Radio
  logic [FRAME_BITS-1:0]   r_shift;        // frame bits, bit 0 is on the line
  logic [BW-1:0]           r_bit_cnt;
  logic [CW-1:0]           r_clk_cnt;
  logic                    r_busy;
  logic [PIPE_STAGES-1:0]  r_pipe;

  logic                    w_grant_radio;
  logic                    w_radio_ready;
  logic                    w_wire_ready;
  logic                    w_handshake;
  logic                    w_bit_end;
  logic                    w_frame_end;
  logic                    w_ser_bit;
  logic [DATA_WIDTH-1:0]   w_data;

  function automatic logic even_parity(input logic tag, input logic [DATA_WIDTH-1:0] data);
    return tag ^ (^data);
  endfunction

  // Arbitration, handshake and next-state decode
  always_comb begin
    w_state_next  = r_state;
    w_grant_radio = 1'b0;
    w_radio_ready = 1'b0;
    w_wire_ready  = 1'b0;
    w_ser_bit     = 1'b1;
    w_bit_end     = (r_clk_cnt == LAST_CLK);
    w_frame_end   = w_bit_end && (r_bit_cnt == LAST_BIT);
    // When both sources contend, the one not served last time wins.
    if (RadioValid && WireValid) begin
      w_grant_radio = ~r_last_radio;
    end else begin
      w_grant_radio = RadioValid;
    end
    case (r_state)
      S_IDLE: begin
        if (Reset_N) begin
          w_radio_ready = RadioValid & w_grant_radio;
          w_wire_ready  = WireValid & ~w_grant_radio;
        end else begin
          w_radio_ready = 1'b0;
          w_wire_ready  = 1'b0;
        end
        if (w_radio_ready || w_wire_ready) begin
          w_state_next = S_SEND;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_SEND: begin
        w_ser_bit = r_shift[0];
        if (w_frame_end) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_SEND;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign w_handshake = w_radio_ready | w_wire_ready;
  assign w_data      = w_grant_radio ? RadioData : WireData;

  // State register
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Frame load on handshake, bit/cycle counting and shifting while sending
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      r_last_radio <= 1'b0;
      r_shift      <= {FRAME_BITS{1'b1}};
      r_bit_cnt    <= '0;
      r_clk_cnt    <= '0;
      r_busy       <= 1'b0;
    end else if (r_state == S_IDLE) begin
      r_bit_cnt <= '0;
      r_clk_cnt <= '0;
      if (w_handshake) begin
        r_shift      <= {1'b1, even_parity(w_grant_radio, w_data), w_data, w_grant_radio, 1'b0};
        r_last_radio <= w_grant_radio;
        r_busy       <= 1'b1;
      end else begin
        r_busy <= 1'b0;
      end
    end else begin
      if (w_bit_end) begin
        r_clk_cnt <= '0;
        r_shift   <= {1'b1, r_shift[FRAME_BITS-1:1]};
        if (w_frame_end) begin
          r_bit_cnt <= '0;
          r_busy    <= 1'b0;
        end else begin
          r_bit_cnt <= r_bit_cnt + BW'(1);
        end
      end else begin
        r_clk_cnt <= r_clk_cnt + CW'(1);
      end
    end
  end

  // Output relay; reset forces the whole chain to the idle level at once
  always_ff @(posedge Clock or negedge Reset_N) begin
    if (!Reset_N) begin
      r_pipe <= {PIPE_STAGES{1'b1}};
    end else begin
      r_pipe[0] <= w_ser_bit;
      for (int i = 1; i < PIPE_STAGES; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign RadioReady     = w_radio_ready;
  assign WireReady      = w_wire_ready;
  assign Busy           = r_busy;
  assign Transmit_Plus  = r_pipe[PIPE_STAGES-1];
  assign Transmit_Minus = ~r_pipe[PIPE_STAGES-1];

endmodule

// File: tb/tb_merge_radio_transmit.sv
// tb_merge_radio_transmit
// Directed scenarios plus randomized traffic, checked cycle by cycle against
// a frame-queue reference model of the transmitter.
module tb_merge_radio_transmit;

  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int PS  = 3;
  localparam int FB  = DW + 4;

  logic          Clock;
  logic          Reset_N;
  logic [DW-1:0] RadioData;
  logic          RadioValid;
  logic          RadioReady;
  logic [DW-1:0] WireData;
  logic          WireValid;
  logic          WireReady;
  logic          Transmit_Plus;
  logic          Transmit_Minus;
  logic          Busy;

  merge_radio_transmit #(
    .DATA_WIDTH  (DW),
    .CLKS_PER_BIT(CPB),
    .PIPE_STAGES (PS)
  ) dut (
    .Clock         (Clock),
    .Reset_N       (Reset_N),
    .RadioData     (RadioData),
    .RadioValid    (RadioValid),
    .RadioReady    (RadioReady),
    .WireData      (WireData),
    .WireValid     (WireValid),
    .WireReady     (WireReady),
    .Transmit_Plus (Transmit_Plus),
    .Transmit_Minus(Transmit_Minus),
    .Busy          (Busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  logic pin_log [0:8191];
  logic wr_log  [0:8191];

  // reference model state
  logic frame_q[$];      // serializer-level line value for each upcoming cycle
  logic pin_q[$];        // values in flight through the output relay
  logic last_radio = 1'b0;
  logic last_hs_r  = 1'b0;
  logic last_hs_w  = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    frame_q.delete();
    pin_q.delete();
    for (int i = 0; i < PS; i++) pin_q.push_back(1'b1);
    last_radio = 1'b0;
  endtask

  task automatic push_frame(input logic tag, input logic [DW-1:0] d);
    logic b;
    for (int i = 0; i < FB; i++) begin
      if (i == 0)            b = 1'b0;
      else if (i == 1)       b = tag;
      else if (i <= DW + 1)  b = d[i-2];
      else if (i == DW + 2)  b = tag ^ (^d);
      else                   b = 1'b1;
      repeat (CPB) frame_q.push_back(b);
    end
  endtask

  // Samples the DUT mid-cycle and advances the reference model by one cycle.
  task automatic eval_cycle();
    logic idle_e, ser_e, pin_e, g_radio, hs_r, hs_w, dummy;
    @(negedge Clock);
    cyc++;
    pin_log[cyc] = Transmit_Plus;
    wr_log[cyc]  = WireReady;
    hs_r = 1'b0;
    hs_w = 1'b0;
    if (!Reset_N) begin
      model_reset();
      check_val("rst_plus",  Transmit_Plus,  1);
      check_val("rst_minus", Transmit_Minus, 0);
      check_val("rst_busy",  Busy,           0);
      check_val("rst_rrdy",  RadioReady,     0);
      check_val("rst_wrdy",  WireReady,      0);
    end else begin
      idle_e = (frame_q.size() == 0);
      ser_e  = idle_e ? 1'b1 : frame_q[0];
      pin_e  = pin_q.pop_front();
      pin_q.push_back(ser_e);
      check_val("plus",  Transmit_Plus,  pin_e);
      check_val("minus", Transmit_Minus, !pin_e);
      check_val("busy",  Busy,           !idle_e);
      if (idle_e) begin
        if (RadioValid && WireValid) g_radio = !last_radio;
        else                         g_radio = RadioValid;
        hs_r = RadioValid && g_radio;
        hs_w = WireValid && !g_radio;
      end
      check_val("radio_ready", RadioReady, hs_r);
      check_val("wire_ready",  WireReady,  hs_w);
      if (!idle_e) dummy = frame_q.pop_front();
      if (hs_r) push_frame(1'b1, RadioData);
      if (hs_w) push_frame(1'b0, WireData);
      if (hs_r || hs_w) last_radio = hs_r;
    end
    last_hs_r = hs_r;
    last_hs_w = hs_w;
  endtask

  // Runs n cycles, withdrawing each Valid once it has been accepted.
  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clock); #1;
      if (last_hs_r) RadioValid = 1'b0;
      if (last_hs_w) WireValid  = 1'b0;
      eval_cycle();
    end
  endtask

  // Compares the pin log of a frame handshaken at t0 with a fixed bit list.
  task automatic check_frame(input string tag, input int t0, input logic [FB-1:0] bits);
    for (int i = 0; i < FB; i++)
      for (int c = 0; c < CPB; c++)
        check_val(tag, pin_log[t0 + 1 + PS + CPB*i + c], bits[i]);
    check_val({tag, "_idle"}, pin_log[t0 + 1 + PS + CPB*FB], 1);
  endtask

  initial begin
    int t0;
    int first;
    int zeros;
    Reset_N = 1'b1; RadioValid = 1'b0; WireValid = 1'b0;
    RadioData = 8'h00; WireData = 8'h00;
    model_reset();
    #1;
    // reset held with both sources valid
    Reset_N = 1'b0; RadioValid = 1'b1; WireValid = 1'b1;
    repeat (3) begin
      @(posedge Clock); #1;
      eval_cycle();
    end

    // radio-only frame, accepted in the reset-release cycle
    @(posedge Clock); #1;
    Reset_N = 1'b1; WireValid = 1'b0; RadioValid = 1'b1; RadioData = 8'hA5;
    eval_cycle();
    t0 = cyc;
    check_val("radio_ready_T", RadioReady, 1);
    run_cycles(60);
    check_frame("frame_A5", t0, 12'b1110_1001_0110);

    // wire-only frame
    @(posedge Clock); #1;
    WireData = 8'h3C; WireValid = 1'b1;
    eval_cycle();
    t0 = cyc;
    check_val("wire_ready_T", WireReady, 1);
    run_cycles(60);
    check_frame("frame_3C", t0, 12'b1000_1111_0000);

    // both sources continuously valid: strict alternation, 49-cycle spacing
    @(posedge Clock); #1;
    RadioData = 8'h01; WireData = 8'h02; RadioValid = 1'b1; WireValid = 1'b1;
    eval_cycle();
    t0 = cyc;
    check_val("both_first_radio", RadioReady, 1);
    repeat (200) begin
      @(posedge Clock); #1;
      eval_cycle();
    end
    for (int k = 0; k < 4; k++) begin
      check_val("alt_start",     pin_log[t0 + 1 + PS + 49*k], 0);
      check_val("alt_gap_idle",  pin_log[t0 + PS + 49*k], 1);
      check_val("alt_tag",       pin_log[t0 + 1 + PS + 49*k + CPB], (k % 2 == 0) ? 1 : 0);
    end
    @(posedge Clock); #1;
    RadioValid = 1'b0; WireValid = 1'b0;
    eval_cycle();
    run_cycles(60);

    // reset pulled during bit 5 of a frame
    @(posedge Clock); #1;
    RadioData = 8'h5A; RadioValid = 1'b1;
    eval_cycle();
    t0 = cyc;
    run_cycles(20);
    @(posedge Clock); #1;
    Reset_N = 1'b0;
    #1;
    check_val("abort_plus",  Transmit_Plus,  1);
    check_val("abort_minus", Transmit_Minus, 0);
    check_val("abort_busy",  Busy,           0);
    eval_cycle();
    @(posedge Clock); #1;
    eval_cycle();
    @(posedge Clock); #1;
    Reset_N = 1'b1; RadioValid = 1'b0; WireValid = 1'b0;
    eval_cycle();
    t0 = cyc;
    run_cycles(60);
    zeros = 0;
    for (int c = t0; c <= t0 + 60; c++) if (pin_log[c] == 1'b0) zeros++;
    check_val("no_residual", zeros, 0);

    // Ready gating: wire waits through a radio frame
    @(posedge Clock); #1;
    RadioData = 8'($urandom); RadioValid = 1'b1;
    eval_cycle();
    t0 = cyc;
    run_cycles(9);
    @(posedge Clock); #1;
    WireData = 8'($urandom); WireValid = 1'b1;
    eval_cycle();
    run_cycles(120);
    first = -1;
    for (int c = t0 + 1; c <= t0 + 100; c++) if (wr_log[c] && first < 0) first = c;
    check_val("wire_first_ready", first, t0 + 49);

    // randomized traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(posedge Clock); #1;
      if (!Reset_N) Reset_N = 1'b1;
      else if ($urandom_range(0, 799) == 0) Reset_N = 1'b0;
      if (last_hs_r || !RadioValid) begin
        RadioValid = ($urandom_range(0, 2) == 0);
        RadioData  = 8'($urandom);
      end else if ($urandom_range(0, 49) == 0) begin
        RadioValid = 1'b0;
      end
      if (last_hs_w || !WireValid) begin
        WireValid = ($urandom_range(0, 2) == 0);
        WireData  = 8'($urandom);
      end else if ($urandom_range(0, 49) == 0) begin
        WireValid = 1'b0;
      end
      eval_cycle();
    end
    @(posedge Clock); #1;
    Reset_N = 1'b1; RadioValid = 1'b0; WireValid = 1'b0;
    eval_cycle();
    run_cycles(60);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/merge_radio_transmit.md
Name: merge_radio_transmit

Overview:
- Transmit-side counterpart of the split-radio receive path.
- Merges two byte sources, Radio and Wire, onto one differential transmit pair (Transmit_Plus/Transmit_Minus).
- Round-robin arbitration between the sources; serial framing; a source tag bit so the far-end splitter can route each frame back to the radio or wire branch.
- Output passes through a PIPE_STAGES-deep register chain, matching the receive path's three-stage differential relay.

Parameters:
DATA_WIDTH, 8, payload bits per frame.
CLKS_PER_BIT, 4, clock cycles each serial bit is held on the line (>=1).
PIPE_STAGES, 3, output register stages between the serializer and the pins (>=1).

Ports:
Clock  input  1  single clock; all state on rising edge.
Reset_N  input  1  asynchronous, active-low reset.
RadioData  input  DATA_WIDTH  radio payload.
RadioValid  input  1  radio payload valid.
RadioReady  output  1  radio payload accepted this cycle when RadioValid&RadioReady.
WireData  input  DATA_WIDTH  wire payload.
WireValid  input  1  wire payload valid.
WireReady  output  1  wire payload accepted this cycle when WireValid&WireReady.
Transmit_Plus  output  1  serial line, true polarity.
Transmit_Minus  output  1  serial line, complement; always ~Transmit_Plus.
Busy  output  1  high while a frame is being serialized.

Behaviour:
- Reset (Reset_N low, asynchronous):
  - State=IDLE; bit and cycle counters 0; LastGrant=Wire.
  - All pipeline stages=1, so Transmit_Plus=1, Transmit_Minus=0.
  - Busy=0; RadioReady=WireReady=0.
- Frame, DATA_WIDTH+4 bits, each held CLKS_PER_BIT cycles:
  - start=0;
  - tag (1=Radio, 0=Wire);
  - data, LSB first;
  - parity = XOR(tag, data), i.e. even parity over tag+data;
  - stop=1.
- Idle line level is 1.
- States:
  - IDLE: serializer drives 1.
    - Grant = the only valid source. If both are valid, the source not equal to LastGrant.
    - Ready is high combinationally to the granted source only, and only in IDLE with Reset_N high.
    - Ready may depend on Valid. Valid must not depend on Ready.
    - On handshake: latch data and tag, update LastGrant, go to SEND next cycle.
  - SEND: shift out the frame. Counter runs 0..CLKS_PER_BIT-1 per bit.
    - After the last cycle of the stop bit, go to IDLE.
    - Both Ready outputs are 0 throughout SEND.
- Latency:
  - Handshake at cycle T: start bit enters the pipeline at T+1 and reaches the pins at T+1+PIPE_STAGES.
  - Frame occupies (DATA_WIDTH+4)*CLKS_PER_BIT cycles at the pins.
- Back-to-back frames:
  - Earliest next handshake is in the IDLE cycle right after the stop bit ends.
  - This gives exactly one idle (1) cycle between consecutive stop and start bits.
- Busy: 1 from T+1 through the last stop-bit cycle at the serializer (pre-pipeline).
- Sources are never dropped. A source whose Valid stays high while the other is served is granted next.
  - With both sources continuously valid, grants strictly alternate Radio, Wire, Radio, ...
- Valid deasserted before handshake: no frame, no state change.
- Reset mid-frame:
  - Frame aborted; line forced to 1/0 immediately (asynchronous), including the pipeline contents.
  - The data is not retransmitted after reset release.
- Transmit_Minus is always the exact complement of Transmit_Plus, including during reset.

Test Plan (DATA_WIDTH=8, CLKS_PER_BIT=4, PIPE_STAGES=3):
- Reset check:
  - Stimulus: hold Reset_N low, drive both Valid=1.
  - Response: Plus=1, Minus=0, Busy=0, both Ready=0.
- Radio-only frame:
  - Stimulus: release reset; RadioData=0xA5, RadioValid=1.
  - Response: RadioReady=1 in the same cycle (T).
  - Pins from T+4: 0,1,1,0,1,0,0,1,0,1,1,1, each bit 4 cycles (48 cycles), then idle 1.
- Wire-only frame:
  - Stimulus: WireData=0x3C.
  - Response: pins 0,0,0,0,1,1,1,1,0,0,0,1 (tag 0, parity 0).
- Both sources valid continuously:
  - Stimulus: Radio=0x01, Wire=0x02.
  - Response: first grant Radio; frames alternate R,W,R,W.
  - Start bits are 49 cycles apart (48 + 1 idle).
- Reset mid-frame:
  - Stimulus: pull Reset_N low at bit 5 of a frame.
  - Response: Plus=1 and Minus=0 immediately.
  - After release, no residual bits; line idle until a new handshake.
- Ready gating:
  - Stimulus: assert WireValid during SEND.
  - Response: WireReady stays 0 until IDLE; handshake in the first IDLE cycle.
